// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: tick-driven BCD stopwatch with start/stop/clear FSM and sticky wrap flag.
// Define STOPWATCH_LAP_EN to build the lap display-freeze register.
module stopwatch_bcd #(
    parameter int DIGITS = 4
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t state, state_nx;
    logic [4*DIGITS-1:0] count, count_nx, count_inc;
    logic carry, ov_nx, hold_nx;
`ifdef STOPWATCH_LAP_EN
    logic lap_hold;
`else
    logic unused_lap;
    assign unused_lap = lap;
`endif
    // carry survives the loop only when every digit was 9, i.e. on wrap
    always_comb begin
        count_inc = count;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i+:4] == 4'd9) begin
                    count_inc[4*i+:4] = 4'd0;
                end else begin
                    count_inc[4*i+:4] = count[4*i+:4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end
    always_comb begin
        state_nx = state;
        count_nx = count;
        ov_nx = overflow;
        case (state)
            IDLE: begin
                if (clear) begin
                    count_nx = '0;
                    ov_nx = 1'b0;
                end else if (start_stop) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    count_nx = count_inc;
                    ov_nx = overflow | carry;
                end
                if (start_stop) state_nx = STOP;
            end
            STOP: begin
                if (clear) begin
                    state_nx = IDLE;
                    count_nx = '0;
                    ov_nx = 1'b0;
                end else if (start_stop) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef STOPWATCH_LAP_EN
        hold_nx = (state == RUN && !start_stop) ? (lap_hold ^ lap) : 1'b0;
`else
        hold_nx = 1'b0;
`endif
    end
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            bcd_out  <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            bcd_out  <= hold_nx ? bcd_out : count_nx;
            running  <= (state_nx == RUN);
            overflow <= ov_nx;
        end
    end
`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) lap_hold <= 1'b0;
        else     lap_hold <= hold_nx;
    end
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: vector table, directed corner sequences and random run against an integer model.
module tb_stopwatch_bcd;
    logic clkin = 1'b0, rst = 1'b1, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [15:0] bcd_out;
    logic running, overflow;
    int passed = 0, total = 0;
    int m_state, m_count, m_disp;
    bit m_ov, m_hold;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    stopwatch_bcd #(.DIGITS(4)) dut (
        .clkin(clkin), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .bcd_out(bcd_out), .running(running), .overflow(overflow)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        bit t, s, c, l;
        logic [15:0] b;
        bit r, o;
    } vec_t;

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i+:4] = 4'((v / p) % 10);
            p *= 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_disp = 0; m_ov = 0; m_hold = 0;
    endtask

    // states: 0 idle, 1 run, 2 stop; count kept as a plain integer modulo 10000
    task automatic model_step(bit t, bit s, bit c, bit l);
        if (m_state == 1) begin
            if (t) begin
                m_count++;
                if (m_count == 10000) begin m_count = 0; m_ov = 1; end
            end
            if (s) begin m_state = 2; m_hold = 0; end
            else if (l && LAP_EN) m_hold = !m_hold;
        end else if (c) begin
            m_state = 0; m_count = 0; m_ov = 0;
        end else if (s) begin
            m_state = 1;
        end
        if (!m_hold) m_disp = m_count;
    endtask

    task automatic cmp(string name, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic expect_out(string tag, logic [15:0] b, bit r, bit o);
        cmp({tag, ".bcd"}, bcd_out, b);
        cmp({tag, ".running"}, {15'd0, running}, {15'd0, r});
        cmp({tag, ".overflow"}, {15'd0, overflow}, {15'd0, o});
    endtask

    task automatic check_model(string tag);
        expect_out(tag, to_bcd(m_disp), m_state == 1, m_ov);
    endtask

    task automatic drive(bit t, bit s, bit c, bit l);
        @(negedge clkin);
        tick = t; start_stop = s; clear = c; lap = l;
        @(posedge clkin);
        #1;
        model_step(t, s, c, l);
        tick = 0; start_stop = 0; clear = 0; lap = 0;
    endtask

    task automatic ticks(int n);
        repeat (n) drive(1, 0, 0, 0);
    endtask

    vec_t tbl[14];

    initial begin
        tbl = '{
            '{1,1,0,0, 16'h0000, 1, 0},
            '{1,0,0,0, 16'h0001, 1, 0},
            '{1,0,0,0, 16'h0002, 1, 0},
            '{0,0,1,0, 16'h0002, 1, 0},
            '{1,0,0,0, 16'h0003, 1, 0},
            '{1,1,0,0, 16'h0004, 0, 0},
            '{1,0,0,0, 16'h0004, 0, 0},
            '{0,1,0,0, 16'h0004, 1, 0},
            '{0,0,0,0, 16'h0004, 1, 0},
            '{1,0,0,0, 16'h0005, 1, 0},
            '{0,1,0,0, 16'h0005, 0, 0},
            '{0,1,1,0, 16'h0000, 0, 0},
            '{1,0,0,0, 16'h0000, 0, 0},
            '{0,0,1,0, 16'h0000, 0, 0}
        };
        model_reset();
        #12;
        expect_out("reset", 16'h0000, 0, 0);
        @(negedge clkin) rst = 0;

        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].s, tbl[i].c, tbl[i].l);
            expect_out($sformatf("vec%0d", i), tbl[i].b, tbl[i].r, tbl[i].o);
        end

        drive(0, 1, 0, 0);
        ticks(123);
        expect_out("pre_rst", 16'h0123, 1, 0);
        #2 rst = 1;
        #1 expect_out("async_rst", 16'h0000, 0, 0);
        model_reset();
        @(negedge clkin) rst = 0;

        drive(0, 1, 0, 0);
        ticks(12);
        drive(0, 1, 0, 0);
        expect_out("stop12", 16'h0012, 0, 0);
        ticks(3);
        expect_out("stop_hold", 16'h0012, 0, 0);
        drive(0, 0, 1, 0);
        expect_out("clear12", 16'h0000, 0, 0);

        drive(0, 1, 0, 0);
        ticks(9998);
        expect_out("pre9998", 16'h9998, 1, 0);
        ticks(1);
        expect_out("at9999", 16'h9999, 1, 0);
        ticks(1);
        expect_out("wrap", 16'h0000, 1, 1);
        ticks(1);
        expect_out("post_wrap", 16'h0001, 1, 1);
        drive(0, 0, 1, 0);
        expect_out("run_clear_ign", 16'h0001, 1, 1);
        drive(0, 1, 0, 0);
        expect_out("stop_ov", 16'h0001, 0, 1);
        drive(0, 0, 1, 0);
        expect_out("clear_ov", 16'h0000, 0, 0);

        drive(0, 1, 0, 0);
        ticks(9);
        drive(1, 1, 0, 0);
        expect_out("tick_stop", 16'h0010, 0, 0);
        drive(0, 1, 1, 0);
        expect_out("clr_ss_stop", 16'h0000, 0, 0);

        drive(0, 1, 0, 0);
        ticks(5);
        drive(0, 0, 0, 1);
        ticks(7);
        expect_out("lap_freeze", LAP_EN ? 16'h0005 : 16'h0012, 1, 0);
        drive(0, 0, 0, 1);
        expect_out("lap_release", 16'h0012, 1, 0);
        drive(0, 0, 0, 1);
        ticks(2);
        expect_out("lap_again", LAP_EN ? 16'h0012 : 16'h0014, 1, 0);
        drive(0, 1, 0, 1);
        expect_out("lap_stop", 16'h0014, 0, 0);
        drive(0, 0, 0, 1);
        expect_out("lap_in_stop", 16'h0014, 0, 0);
        drive(0, 0, 1, 0);
        check_model("model_sync");

        for (int n = 0; n < 4000; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Tick-driven BCD elapsed-time counter with start/stop/clear control FSM.
- Sits directly downstream of the programmable tick divider. Consumes its one-cycle `tick` pulse (typically 1 ms or 10 ms) and produces packed BCD digits for the 7-segment decoder stage.
- All outputs are registered; there is one clock domain.

Parameters:
- DIGITS, 4, number of BCD digits counted (digit 0 = least significant).

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle count-enable pulse from the tick divider.
- start_stop  input  1  one-cycle pulse; toggles run/stop.
- clear  input  1  one-cycle pulse; zeroes the count when not running.
- lap  input  1  one-cycle pulse; display freeze toggle (see Optional Feature).
- bcd_out  output  4*DIGITS  packed BCD digits; digit k at bits [4k+3:4k].
- running  output  1  high while in state RUN.
- overflow  output  1  sticky flag set on wrap from all-9s to all-0s.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, bcd_out=0, running=0, overflow=0, lap_hold=0. Reset asserted mid-count aborts immediately; nothing is retained.
- Inputs start_stop, clear, lap and tick are assumed already synchronous, single-cycle pulses. The block performs no edge detection.
- States:
  - IDLE: count=0, stopped.
  - RUN: counting.
  - STOP: paused, count held.
- Transitions, evaluated each clkin edge:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> STOP.
  - STOP + start_stop -> RUN.
  - STOP + clear -> IDLE (count=0, overflow=0).
  - IDLE + clear -> IDLE (overflow=0).
  - RUN + clear -> ignored; state and count unchanged.
- Simultaneous start_stop and clear:
  - In STOP or IDLE, clear wins and the next state is IDLE.
  - In RUN, start_stop applies and clear is ignored.
- Increment rule: count increments only when the current state is RUN and tick=1.
  - A tick coinciding with start_stop in RUN is still counted; the stop takes effect after it.
  - A tick coinciding with the transition into RUN is not counted.
- BCD arithmetic:
  - Digit 0 increments.
  - Any digit at 9 that receives a carry becomes 0 and carries into the next digit.
  - Digits never hold values 10-15.
- Wrap: on a counted tick with all digits at 9, count becomes 0 and overflow sets.
  - Counting continues after the wrap.
  - overflow stays high until clear or rst.
- Latency: bcd_out reflects a counted tick on the clkin edge following the tick cycle (1-cycle latency); bcd_out is a register.
- running is registered and equals (state==RUN). It changes on the same edge as the state.
- With no tick activity the count is static in every state.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: lap implements a display freeze.
  - In RUN, a lap pulse sets lap_hold=1. bcd_out then holds its value from that edge while the internal count keeps incrementing.
  - A second lap pulse clears lap_hold, and bcd_out shows the live count on the next edge.
  - Entering STOP or IDLE clears lap_hold, so bcd_out shows the live count.
  - lap outside RUN is ignored.
  - A lap pulse coinciding with start_stop in RUN: the stop wins and lap_hold=0.
- Undefined: lap is ignored, no lap_hold register is built, and bcd_out always shows the live count.

Test Plan:
- rst pulse mid-run with count=0x0123 -> bcd_out=0x0000, running=0, overflow=0 immediately (asynchronous), without waiting for a clock edge.
- start_stop, then 12 ticks, then start_stop -> bcd_out=0x0012, running=0. Additional ticks leave bcd_out at 0x0012. clear -> 0x0000.
- Preload to 0x9998 via 9998 ticks in RUN, then 2 ticks -> bcd_out=0x9999, then 0x0000 with overflow=1. Next tick -> 0x0001, overflow still 1. Stop, then clear -> overflow=0.
- In RUN at 0x0009, apply start_stop and tick in the same cycle -> bcd_out=0x0010, state STOP. Apply clear and start_stop in the same cycle in STOP -> IDLE, 0x0000.
- In RUN, clear alone -> ignored, count and running unchanged. In IDLE, start_stop and tick in the same cycle -> RUN, bcd_out remains 0x0000.
- STOPWATCH_LAP_EN defined: in RUN at 0x0005, lap, then 7 ticks -> bcd_out=0x0005. Second lap -> bcd_out=0x0012. Macro undefined: the same stimulus gives live 0x0012 throughout.
